// File: rtl/empacotador_matriz_if.sv
// Element stream in, packed matrix out, for the determinant ALU producer.
// slave = packer side, master = host/consumer side.
interface empacotador_matriz_if #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 5
);
  logic                            start;
  logic [1:0]                      tamanho_matriz;
  logic signed [DATA_W-1:0]        elem_in;
  logic                            elem_valid;
  logic                            elem_ready;
  logic [MAX_N*MAX_N*DATA_W-1:0]   matriz;
  logic [1:0]                      tamanho_out;
  logic                            matriz_valid;
  logic                            matriz_ack;
  logic                            busy;

  modport slave (
    input  start,
    input  tamanho_matriz,
    input  elem_in,
    input  elem_valid,
    input  matriz_ack,
    output elem_ready,
    output matriz,
    output tamanho_out,
    output matriz_valid,
    output busy
  );

  modport master (
    output start,
    output tamanho_matriz,
    output elem_in,
    output elem_valid,
    output matriz_ack,
    input  elem_ready,
    input  matriz,
    input  tamanho_out,
    input  matriz_valid,
    input  busy
  );
endinterface

// File: rtl/empacotador_matriz.sv
// Packs row-major signed elements into a 200-bit matrix bus.
// MATRIZ_TRANSPOSE_EN: pack the transpose (slot c*n+r).
module empacotador_matriz #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  empacotador_matriz_if.slave bus
);
  localparam int SLOTS = MAX_N * MAX_N;
  localparam int CW    = $clog2(SLOTS);
  localparam int BW    = SLOTS * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  state_t        state;
  logic [BW-1:0] matriz_q;
  logic [1:0]    size_q;
  logic [CW-1:0] count;
  logic [CW-1:0] last_idx;
  logic [CW-1:0] slot;
  logic          valid_q;
  logic          busy_q;
  logic          xfer;

  assign xfer = (state == LOAD) && bus.elem_valid;

  // Index of the final element for the latched size.
  always_comb begin
    last_idx = '0;
    unique case (size_q)
      2'b00: last_idx = CW'(3);
      2'b01: last_idx = CW'(8);
      2'b10: last_idx = CW'(15);
      2'b11: last_idx = CW'(24);
    endcase
  end

`ifdef MATRIZ_TRANSPOSE_EN
  localparam int IW = $clog2(MAX_N);

  logic [IW-1:0] row;
  logic [IW-1:0] col;
  logic [IW-1:0] n_m1;
  logic [CW-1:0] n_w;
  logic [CW-1:0] slot_q;

  assign n_m1 = IW'(size_q) + IW'(1);
  assign n_w  = CW'(size_q) + CW'(2);
  assign slot = slot_q;

  // Walk (r,c) and track slot c*n+r incrementally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row    <= '0;
      col    <= '0;
      slot_q <= '0;
    end else if (state == IDLE && bus.start) begin
      row    <= '0;
      col    <= '0;
      slot_q <= '0;
    end else if (xfer) begin
      if (col == n_m1) begin
        col    <= '0;
        row    <= row + IW'(1);
        slot_q <= CW'(row) + CW'(1);
      end else begin
        col    <= col + IW'(1);
        slot_q <= slot_q + n_w;
      end
    end
  end
`else
  assign slot = count;
`endif

  // Main IDLE/LOAD/HOLD controller with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      matriz_q <= '0;
      size_q   <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            size_q   <= bus.tamanho_matriz;
            matriz_q <= '0;
            count    <= '0;
            busy_q   <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            for (int k = 0; k < SLOTS; k++) begin
              if (slot == CW'(k)) begin
                matriz_q[k*DATA_W +: DATA_W] <= bus.elem_in;
              end
            end
            count <= count + CW'(1);
            if (count == last_idx) begin
              valid_q <= 1'b1;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.matriz_ack) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Ready follows state alone so it drops the moment reset asserts.
  assign bus.elem_ready   = (state == LOAD);
  assign bus.matriz       = matriz_q;
  assign bus.tamanho_out  = size_q;
  assign bus.matriz_valid = valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_empacotador_matriz.sv
// Bench for empacotador_matriz: random loads vs an index-arithmetic model.
// Honours MATRIZ_TRANSPOSE_EN in the model.
module tb_empacotador_matriz;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] elems [25];

  empacotador_matriz_if bus ();

  empacotador_matriz dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bus after the first cnt elements of an n x n matrix.
  function automatic logic [199:0] model(input int n, input int cnt);
    logic [199:0] m;
    int r;
    int c;
    int s;
    m = '0;
    for (int i = 0; i < cnt; i++) begin
      r = i / n;
      c = i % n;
`ifdef MATRIZ_TRANSPOSE_EN
      s = c * n + r;
`else
      s = r * n + c;
`endif
      m[s*8 +: 8] = elems[i];
    end
    return m;
  endfunction

  // gap: 0 valid always, 1 toggle 1/0, 2 random.
  // inj >= 0: pulse start(size 11)+ack when that element is offered.
  task automatic run_load(input int sz, input int gap,
                          input int inj, output int edges);
    int n;
    int nn;
    int idx;
    bit injd;
    bit ok;
    logic [199:0] exp_m;
    n = sz + 2;
    nn = n * n;
    idx = 0;
    injd = 0;
    bus.tamanho_matriz = 2'(sz);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edges = 1;
    while (idx < nn && edges < 400) begin
      case (gap)
        0: bus.elem_valid = 1'b1;
        1: bus.elem_valid = (edges % 2 == 1);
        default: bus.elem_valid = 1'($urandom_range(0, 1));
      endcase
      bus.elem_in = elems[idx];
      if (inj >= 0 && idx == inj && !injd) begin
        bus.start = 1'b1;
        bus.tamanho_matriz = 2'b11;
        bus.matriz_ack = 1'b1;
        injd = 1;
      end
      checks++;
      if (bus.elem_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready got %b want 1", bus.elem_ready);
      end
      ok = bus.elem_valid;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.matriz_ack = 1'b0;
      edges++;
      if (ok) idx++;
      exp_m = model(n, idx);
      checks++;
      if (bus.matriz !== exp_m) begin
        errors++;
        $display("FAIL load_matriz got %h want %h", bus.matriz, exp_m);
      end
      if (idx < nn) begin
        checks++;
        if (bus.matriz_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_valid got %b want 0", bus.matriz_valid);
        end
      end
    end
    bus.elem_valid = 1'b0;
    checks++;
    if (idx != nn) begin
      errors++;
      $display("FAIL load_timeout got %0d want %0d", idx, nn);
    end
    checks++;
    if (bus.matriz_valid !== 1'b1 || bus.busy !== 1'b1 ||
        bus.elem_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_flags got v%b b%b r%b want v1 b1 r0",
               bus.matriz_valid, bus.busy, bus.elem_ready);
    end
    checks++;
    if (bus.tamanho_out !== 2'(sz)) begin
      errors++;
      $display("FAIL tamanho_out got %b want %b", bus.tamanho_out, 2'(sz));
    end
  endtask

  task automatic do_ack();
    bus.matriz_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.matriz_ack = 1'b0;
    checks++;
    if (bus.matriz_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.elem_ready !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle got v%b b%b r%b want v0 b0 r0",
               bus.matriz_valid, bus.busy, bus.elem_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.tamanho_matriz = 2'b00;
    bus.elem_in = '0;
    bus.elem_valid = 1'b0;
    bus.matriz_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.matriz !== '0 || bus.tamanho_out !== 2'b00 ||
        bus.matriz_valid !== 1'b0 || bus.elem_ready !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got m%h t%b v%b r%b b%b want zeros",
               bus.matriz, bus.tamanho_out, bus.matriz_valid,
               bus.elem_ready, bus.busy);
    end
  endtask

  task automatic test_2x2();
    int edges;
    logic [31:0] want;
`ifdef MATRIZ_TRANSPOSE_EN
    want = 32'h04020301;
`else
    want = 32'h04030201;
`endif
    for (int i = 0; i < 4; i++) elems[i] = 8'(i + 1);
    run_load(0, 0, -1, edges);
    checks++;
    if (edges != 5) begin
      errors++;
      $display("FAIL latency_2x2 got %0d want 5", edges);
    end
    checks++;
    if (bus.matriz[31:0] !== want || bus.matriz[199:32] !== '0) begin
      errors++;
      $display("FAIL bus_2x2 got %h want %h", bus.matriz, want);
    end
    do_ack();
  endtask

  task automatic test_gapped_3x3();
    int edges;
    logic [71:0] want;
`ifdef MATRIZ_TRANSPOSE_EN
    want = 72'h090603080502070401;
`else
    want = 72'h090807060504030201;
`endif
    for (int i = 0; i < 9; i++) elems[i] = 8'(i + 1);
    run_load(1, 1, -1, edges);
    checks++;
    if (bus.matriz[71:0] !== want || bus.matriz[199:72] !== '0) begin
      errors++;
      $display("FAIL bus_3x3 got %h want %h", bus.matriz, want);
    end
    do_ack();
  endtask

  task automatic test_5x5_hold();
    int edges;
    logic [199:0] exp_m;
    elems[0] = 8'h80;
    for (int i = 1; i < 25; i++) elems[i] = 8'(i);
    run_load(3, 0, -1, edges);
    checks++;
    if (edges != 26) begin
      errors++;
      $display("FAIL latency_5x5 got %0d want 26", edges);
    end
    checks++;
    if (bus.matriz[7:0] !== 8'h80 || bus.matriz[199:192] !== 8'h18) begin
      errors++;
      $display("FAIL slots_5x5 got s0=%h s24=%h want 80 18",
               bus.matriz[7:0], bus.matriz[199:192]);
    end
    exp_m = model(5, 25);
    for (int i = 0; i < 10; i++) begin
      bus.elem_valid = 1'b1;
      bus.elem_in = 8'($urandom);
      bus.start = (i == 4);
      bus.tamanho_matriz = 2'b00;
      @(posedge clk);
      #1;
      checks++;
      if (bus.matriz !== exp_m || bus.matriz_valid !== 1'b1 ||
          bus.elem_ready !== 1'b0 || bus.tamanho_out !== 2'b11) begin
        errors++;
        $display("FAIL hold_stable got m%h v%b r%b t%b want m%h v1 r0 t11",
                 bus.matriz, bus.matriz_valid, bus.elem_ready,
                 bus.tamanho_out, exp_m);
      end
    end
    bus.elem_valid = 1'b0;
    bus.start = 1'b0;
    do_ack();
  endtask

  task automatic test_ignored_events();
    int edges;
    for (int i = 0; i < 4; i++) elems[i] = 8'($urandom);
    run_load(0, 0, 2, edges);
    checks++;
    if (edges != 5) begin
      errors++;
      $display("FAIL ignored_latency got %0d want 5", edges);
    end
    bus.start = 1'b1;
    bus.tamanho_matriz = 2'b10;
    bus.matriz_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.matriz_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.elem_ready !== 1'b0 ||
          bus.matriz_valid !== 1'b0) begin
        errors++;
        $display("FAIL start_ack_drop got b%b r%b v%b want 0 0 0",
                 bus.busy, bus.elem_ready, bus.matriz_valid);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    bus.tamanho_matriz = 2'b01;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.elem_valid = 1'b1;
      bus.elem_in = 8'($urandom_range(1, 255));
      @(posedge clk);
      #1;
    end
    bus.elem_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.matriz !== '0 || bus.busy !== 1'b0 ||
        bus.elem_ready !== 1'b0 || bus.matriz_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got m%h b%b r%b v%b want zeros",
               bus.matriz, bus.busy, bus.elem_ready, bus.matriz_valid);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) elems[i] = 8'($urandom);
    run_load(0, 0, -1, edges);
    do_ack();
  endtask

  task automatic test_random();
    int edges;
    int sz;
    logic [199:0] prev;
    for (int t = 0; t < 8; t++) begin
      sz = $urandom_range(0, 3);
      for (int i = 0; i < 25; i++) elems[i] = 8'($urandom);
      run_load(sz, 2, -1, edges);
      prev = model(sz + 2, (sz + 2) * (sz + 2));
      do_ack();
      for (int i = 0; i < 2; i++) begin
        bus.elem_valid = 1'b1;
        bus.elem_in = 8'($urandom);
        @(posedge clk);
        #1;
        checks++;
        if (bus.matriz !== prev || bus.elem_ready !== 1'b0) begin
          errors++;
          $display("FAIL idle_retain got m%h r%b want m%h r0",
                   bus.matriz, bus.elem_ready, prev);
        end
      end
      bus.elem_valid = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_2x2();
    test_gapped_3x3();
    test_5x5_hold();
    test_ignored_events();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
